// File: rtl/alu_station_pkg.sv
// Shared op encoding for the ALU reservation station and its users.
package alu_station_pkg;

    typedef enum logic [4:0] {
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, AUIPC
    } instr_name_t;

endpackage

// File: rtl/alu_station_if.sv
// Issue, CDB snoop and exec-port signals of the ALU reservation station.
interface alu_station_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 6
) ();
    import alu_station_pkg::*;

    logic              iss_valid;
    logic              iss_ready;
    instr_name_t       iss_instr;
    logic [TAGW-1:0]   iss_tag_1;
    logic [TAGW-1:0]   iss_tag_2;
    logic [XLEN-1:0]   iss_data_1;
    logic [XLEN-1:0]   iss_data_2;
    logic [XLEN-1:0]   iss_imm;
    logic [XLEN-1:0]   iss_addr;
    logic [TAGW-1:0]   iss_dst_tag;

    logic              cdb_valid;
    logic [TAGW-1:0]   cdb_tag;
    logic [XLEN-1:0]   cdb_data;

    logic              ex_valid;
    logic              ex_ready;
    instr_name_t       ex_instr;
    logic [XLEN-1:0]   ex_data_1;
    logic [XLEN-1:0]   ex_data_2;
    logic [XLEN-1:0]   ex_imm;
    logic [XLEN-1:0]   ex_addr;
    logic [TAGW-1:0]   ex_dst_tag;

    modport master (
        output iss_valid, iss_instr, iss_tag_1, iss_tag_2, iss_data_1, iss_data_2,
               iss_imm, iss_addr, iss_dst_tag, cdb_valid, cdb_tag, cdb_data, ex_ready,
        input  iss_ready, ex_valid, ex_instr, ex_data_1, ex_data_2, ex_imm, ex_addr,
               ex_dst_tag
    );

    modport slave (
        input  iss_valid, iss_instr, iss_tag_1, iss_tag_2, iss_data_1, iss_data_2,
               iss_imm, iss_addr, iss_dst_tag, cdb_valid, cdb_tag, cdb_data, ex_ready,
        output iss_ready, ex_valid, ex_instr, ex_data_1, ex_data_2, ex_imm, ex_addr,
               ex_dst_tag
    );

endinterface

// File: rtl/alu_station.sv
// Reservation station for the integer ALU: age-ordered compacting queue with CDB
// wakeup, feeding a 1-deep registered exec port with the oldest ready op.
module alu_station
    import alu_station_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAGW  = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    alu_station_if.slave                 bus,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        instr_name_t     instr;
        logic [TAGW-1:0] tag_1;
        logic [TAGW-1:0] tag_2;
        logic [XLEN-1:0] data_1;
        logic [XLEN-1:0] data_2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] addr;
        logic [TAGW-1:0] dst_tag;
    } entry_t;

    entry_t          q_q [DEPTH];
    entry_t          q_d [DEPTH];
    logic [CW-1:0]   count_q, count_d;

    logic            ex_valid_q, ex_valid_d;
    instr_name_t     ex_instr_q, ex_instr_d;
    logic [XLEN-1:0] ex_data_1_q, ex_data_1_d;
    logic [XLEN-1:0] ex_data_2_q, ex_data_2_d;
    logic [XLEN-1:0] ex_imm_q, ex_imm_d;
    logic [XLEN-1:0] ex_addr_q, ex_addr_d;
    logic [TAGW-1:0] ex_dst_tag_q, ex_dst_tag_d;

    // Candidate list: queue after this cycle's snoop, incoming op placed at slot count_q.
    entry_t          cand   [DEPTH+1];
    logic            cand_v [DEPTH];
    entry_t          inc;
    entry_t          sel_e;
    logic            iss_fire;
    logic            ex_free;
    logic            sel_found;
    int              sel_idx;

    function automatic entry_t snoop(entry_t e, logic v, logic [TAGW-1:0] t,
                                     logic [XLEN-1:0] d);
        entry_t r;
        r = e;
        if (v && (t != '0)) begin
            if (r.tag_1 == t) begin
                r.tag_1  = '0;
                r.data_1 = d;
            end
            if (r.tag_2 == t) begin
                r.tag_2  = '0;
                r.data_2 = d;
            end
        end
        return r;
    endfunction

    always_comb begin
        iss_fire = bus.iss_valid && (count_q < CW'(DEPTH));
        ex_free  = !ex_valid_q || bus.ex_ready;

        inc.instr   = bus.iss_instr;
        inc.tag_1   = bus.iss_tag_1;
        inc.tag_2   = bus.iss_tag_2;
        inc.data_1  = bus.iss_data_1;
        inc.data_2  = bus.iss_data_2;
        inc.imm     = bus.iss_imm;
        inc.addr    = bus.iss_addr;
        inc.dst_tag = bus.iss_dst_tag;

        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count_q)) begin
                cand[i]   = snoop(q_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
                cand_v[i] = 1'b1;
            end else begin
                cand[i]   = snoop(inc, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
                cand_v[i] = iss_fire && (i == int'(count_q));
            end
        end
        cand[DEPTH] = '0;

        sel_found = 1'b0;
        sel_idx   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ex_free && !sel_found && cand_v[i] &&
                (cand[i].tag_1 == '0) && (cand[i].tag_2 == '0)) begin
                sel_found = 1'b1;
                sel_idx   = i;
            end
        end
        sel_e = cand[sel_idx];

        // Close the gap left by the dispatched entry so index 0 stays oldest.
        for (int j = 0; j < DEPTH; j++) begin
            q_d[j] = (sel_found && (j >= sel_idx)) ? cand[j+1] : cand[j];
        end

        count_d = count_q + {{(CW-1){1'b0}}, iss_fire} - {{(CW-1){1'b0}}, sel_found};
    end

    always_comb begin
        ex_valid_d   = ex_valid_q && !bus.ex_ready;
        ex_instr_d   = ex_instr_q;
        ex_data_1_d  = ex_data_1_q;
        ex_data_2_d  = ex_data_2_q;
        ex_imm_d     = ex_imm_q;
        ex_addr_d    = ex_addr_q;
        ex_dst_tag_d = ex_dst_tag_q;
        if (sel_found) begin
            ex_valid_d   = 1'b1;
            ex_instr_d   = sel_e.instr;
            ex_data_1_d  = sel_e.data_1;
            ex_data_2_d  = sel_e.data_2;
            ex_imm_d     = sel_e.imm;
            ex_addr_d    = sel_e.addr;
            ex_dst_tag_d = sel_e.dst_tag;
        end
    end

    // Slots at or beyond count are dead, so flush only needs to clear count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                q_q[i] <= q_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= ADDI;
            ex_data_1_q  <= '0;
            ex_data_2_q  <= '0;
            ex_imm_q     <= '0;
            ex_addr_q    <= '0;
            ex_dst_tag_q <= '0;
        end else if (flush) begin
            count_q      <= '0;
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= ADDI;
            ex_data_1_q  <= '0;
            ex_data_2_q  <= '0;
            ex_imm_q     <= '0;
            ex_addr_q    <= '0;
            ex_dst_tag_q <= '0;
        end else begin
            count_q      <= count_d;
            ex_valid_q   <= ex_valid_d;
            ex_instr_q   <= ex_instr_d;
            ex_data_1_q  <= ex_data_1_d;
            ex_data_2_q  <= ex_data_2_d;
            ex_imm_q     <= ex_imm_d;
            ex_addr_q    <= ex_addr_d;
            ex_dst_tag_q <= ex_dst_tag_d;
        end
    end

    assign count          = count_q;
    assign bus.iss_ready  = count_q < CW'(DEPTH);
    assign bus.ex_valid   = ex_valid_q;
    assign bus.ex_instr   = ex_instr_q;
    assign bus.ex_data_1  = ex_data_1_q;
    assign bus.ex_data_2  = ex_data_2_q;
    assign bus.ex_imm     = ex_imm_q;
    assign bus.ex_addr    = ex_addr_q;
    assign bus.ex_dst_tag = ex_dst_tag_q;

endmodule

// File: tb/tb_alu_station.sv
// Bench for alu_station: directed scenarios plus random traffic, checked against a
// queue-based model of the station's issue/wakeup/dispatch rules.
module tb_alu_station;
    import alu_station_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [2:0] count;

    alu_station_if #(.XLEN(32), .TAGW(6)) bus ();

    alu_station #(.XLEN(32), .DEPTH(DEPTH), .TAGW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        instr_name_t instr;
        logic [5:0]  t1;
        logic [5:0]  t2;
        logic [5:0]  dst;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] addr;
    } m_ent_t;

    m_ent_t m_q[$];
    m_ent_t m_ex;
    bit     m_ex_v = 1'b0;
    int     total  = 0;
    int     bad    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic m_ent_t wake(m_ent_t e);
        m_ent_t r = e;
        if (bus.cdb_valid && bus.cdb_tag != 6'd0) begin
            if (r.t1 == bus.cdb_tag) begin r.t1 = 6'd0; r.d1 = bus.cdb_data; end
            if (r.t2 == bus.cdb_tag) begin r.t2 = 6'd0; r.d2 = bus.cdb_data; end
        end
        return r;
    endfunction

    // One clock of the station's rules, from the inputs currently driven.
    task automatic model_step();
        int     pick = -1;
        m_ent_t e;
        if (flush) begin
            m_q.delete();
            m_ex_v = 1'b0;
            return;
        end
        foreach (m_q[i]) m_q[i] = wake(m_q[i]);
        if (bus.iss_valid && m_q.size() < DEPTH) begin
            e.instr = bus.iss_instr;  e.t1 = bus.iss_tag_1;  e.t2 = bus.iss_tag_2;
            e.d1 = bus.iss_data_1;    e.d2 = bus.iss_data_2; e.imm = bus.iss_imm;
            e.addr = bus.iss_addr;    e.dst = bus.iss_dst_tag;
            m_q.push_back(wake(e));
        end
        if (!m_ex_v || bus.ex_ready) begin
            m_ex_v = 1'b0;
            for (int i = 0; i < m_q.size(); i++) begin
                if (pick < 0 && m_q[i].t1 == 6'd0 && m_q[i].t2 == 6'd0) pick = i;
            end
            if (pick >= 0) begin
                m_ex   = m_q[pick];
                m_ex_v = 1'b1;
                m_q.delete(pick);
            end
        end
    endtask

    task automatic check_all();
        chk("iss_ready", 64'(bus.iss_ready), 64'(m_q.size() < DEPTH));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("ex_valid", 64'(bus.ex_valid), 64'(m_ex_v));
        if (m_ex_v) begin
            chk("ex_instr", 64'(bus.ex_instr), 64'(m_ex.instr));
            chk("ex_data_1", 64'(bus.ex_data_1), 64'(m_ex.d1));
            chk("ex_data_2", 64'(bus.ex_data_2), 64'(m_ex.d2));
            chk("ex_imm", 64'(bus.ex_imm), 64'(m_ex.imm));
            chk("ex_addr", 64'(bus.ex_addr), 64'(m_ex.addr));
            chk("ex_dst_tag", 64'(bus.ex_dst_tag), 64'(m_ex.dst));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ex_valid"}, 64'(bus.ex_valid), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_iss_ready"}, 64'(bus.iss_ready), 64'd1);
        chk({tag, "_ex_instr"}, 64'(bus.ex_instr), 64'd0);
        chk({tag, "_ex_data_1"}, 64'(bus.ex_data_1), 64'd0);
        chk({tag, "_ex_data_2"}, 64'(bus.ex_data_2), 64'd0);
        chk({tag, "_ex_imm"}, 64'(bus.ex_imm), 64'd0);
        chk({tag, "_ex_addr"}, 64'(bus.ex_addr), 64'd0);
        chk({tag, "_ex_dst"}, 64'(bus.ex_dst_tag), 64'd0);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_iss(input logic v, input instr_name_t op, input logic [5:0] t1,
                           input logic [5:0] t2, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] imm, input logic [5:0] dst);
        bus.iss_valid  = v;   bus.iss_instr  = op;  bus.iss_tag_1 = t1;
        bus.iss_tag_2  = t2;  bus.iss_data_1 = d1;  bus.iss_data_2 = d2;
        bus.iss_imm    = imm; bus.iss_addr   = imm + 32'h1000;
        bus.iss_dst_tag = dst;
    endtask

    task automatic set_cdb(input logic v, input logic [5:0] tag, input logic [31:0] data);
        bus.cdb_valid = v;
        bus.cdb_tag   = tag;
        bus.cdb_data  = data;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.ex_ready = 1'b1;
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        set_cdb(1'b0, 6'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        @(negedge clk);
        reset = 1'b0;

        // Operands present at issue: exec port loads on the next edge.
        set_iss(1'b1, ADDI, 6'd0, 6'd0, 32'd5, 32'd0, 32'd7, 6'd1);
        tick();
        chk("addi_valid", 64'(bus.ex_valid), 64'd1);
        chk("addi_instr", 64'(bus.ex_instr), 64'(ADDI));
        chk("addi_d1", 64'(bus.ex_data_1), 64'd5);
        chk("addi_imm", 64'(bus.ex_imm), 64'd7);
        chk("addi_count", 64'(count), 64'd0);
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        tick();

        // Late operand woken by CDB two cycles after issue.
        set_iss(1'b1, ADD, 6'd3, 6'd0, 32'd0, 32'd2, 32'd0, 6'd2);
        tick();
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        tick();
        chk("add_wait", 64'(bus.ex_valid), 64'd0);
        set_cdb(1'b1, 6'd3, 32'h10);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        chk("add_d1", 64'(bus.ex_data_1), 64'h10);
        chk("add_dst", 64'(bus.ex_dst_tag), 64'd2);

        // Wakeup in the same cycle as issue is not lost.
        set_iss(1'b1, SUB, 6'd0, 6'd4, 32'd20, 32'd0, 32'd0, 6'd3);
        set_cdb(1'b1, 6'd4, 32'd9);
        tick();
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        set_cdb(1'b0, 6'd0, 32'd0);
        chk("sub_valid", 64'(bus.ex_valid), 64'd1);
        chk("sub_d2", 64'(bus.ex_data_2), 64'd9);

        // Duplicate source tags both capture.
        set_iss(1'b1, XOR, 6'd5, 6'd5, 32'd0, 32'd0, 32'd0, 6'd4);
        tick();
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        set_cdb(1'b1, 6'd5, 32'h55);
        tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        chk("dup_d1", 64'(bus.ex_data_1), 64'h55);
        chk("dup_d2", 64'(bus.ex_data_2), 64'h55);

        // Fill with waiting ops; wake slot 2 first while issue is blocked.
        for (int i = 0; i < DEPTH; i++) begin
            set_iss(1'b1, OR, 6'(10 + i), 6'd0, 32'd0, 32'(i), 32'(i), 6'(20 + i));
            tick();
        end
        chk("full_ready", 64'(bus.iss_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        set_iss(1'b1, ADDI, 6'd0, 6'd0, 32'd1, 32'd0, 32'd0, 6'd40);
        set_cdb(1'b1, 6'd12, 32'hC0);
        tick();
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        chk("wake2_dst", 64'(bus.ex_dst_tag), 64'd22);
        chk("wake2_count", 64'(count), 64'd3);
        bus.ex_ready = 1'b0;
        set_cdb(1'b1, 6'd13, 32'hD0); tick();
        set_cdb(1'b1, 6'd10, 32'hA0); tick();
        set_cdb(1'b1, 6'd11, 32'hB0); tick();
        set_cdb(1'b0, 6'd0, 32'd0);
        bus.ex_ready = 1'b1;
        tick(); chk("order0_dst", 64'(bus.ex_dst_tag), 64'd20);
        tick(); chk("order1_dst", 64'(bus.ex_dst_tag), 64'd21);
        tick(); chk("order2_dst", 64'(bus.ex_dst_tag), 64'd23);
        tick();

        // Stall the exec port, then drain back-to-back.
        bus.ex_ready = 1'b0;
        set_iss(1'b1, ADDI, 6'd0, 6'd0, 32'd1, 32'd0, 32'd0, 6'd30); tick();
        set_iss(1'b1, ADDI, 6'd0, 6'd0, 32'd2, 32'd0, 32'd0, 6'd31); tick();
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_dst", 64'(bus.ex_dst_tag), 64'd30);
            chk("hold_d1", 64'(bus.ex_data_1), 64'd1);
        end
        bus.ex_ready = 1'b1;
        tick(); chk("drain_dst", 64'(bus.ex_dst_tag), 64'd31);
        tick(); chk("drain_empty", 64'(bus.ex_valid), 64'd0);

        // Flush with three queued entries and a held exec op.
        bus.ex_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_iss(1'b1, AND, 6'd0, 6'd0, 32'(i), 32'd0, 32'd0, 6'(50 + i));
            tick();
        end
        chk("preflush_count", 64'(count), 64'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ex", 64'(bus.ex_valid), 64'd0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            set_iss(1'($urandom_range(0, 1)), instr_name_t'($urandom_range(0, 20)),
                    ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 6)) : 6'd0,
                    ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 6)) : 6'd0,
                    $urandom, $urandom, $urandom, 6'($urandom_range(0, 63)));
            set_cdb(1'($urandom_range(0, 1)), 6'($urandom_range(0, 6)), $urandom);
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0;

        // Async reset between edges clears outputs immediately.
        bus.ex_ready = 1'b0;
        set_iss(1'b1, ADDI, 6'd0, 6'd0, 32'd3, 32'd0, 32'd0, 6'd60); tick();
        set_iss(1'b1, ADD, 6'd7, 6'd0, 32'd0, 32'd0, 32'd0, 6'd61); tick();
        set_iss(1'b0, ADDI, 6'd0, 6'd0, 32'd0, 32'd0, 32'd0, 6'd0);
        set_cdb(1'b0, 6'd0, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_reset("async");
        m_q.delete();
        m_ex_v = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        bus.ex_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
